// File: rtl/fetch_unit.sv
// fetch_unit: program counter plus instruction fetch over a req/ack handshake into the instruction register
package opcodes;
  typedef enum logic [1:0] {PcWait = 2'd0, PcInc = 2'd1, PcJmp = 2'd2} PcSel_t;
  typedef enum logic [3:0] {
    NOOP = 4'h0, LOAD = 4'h1, STORE = 4'h2, ADD = 4'h3,
    SUB = 4'h4, AND = 4'h5, OR = 4'h6, XOR = 4'h7,
    JMP = 4'h8, JZ = 4'h9, JNZ = 4'hA, HALT = 4'hF
  } opcodes_t;
endpackage

module fetch_unit #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int IMM_WIDTH = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  opcodes::PcSel_t PcSel,
  input  logic [PC_WIDTH-1:0] JmpAddr,
  output logic IMemReq,
  output logic [PC_WIDTH-1:0] IMemAddr,
  input  logic IMemAck,
  input  logic [INSTR_WIDTH-1:0] IMemData,
  output opcodes::opcodes_t OpCode,
  output logic [IMM_WIDTH-1:0] Imm,
  output logic InstrValid,
  output logic [PC_WIDTH-1:0] Pc
);
  typedef enum logic [1:0] {FETCH, WAIT, READY} state_t;
  state_t state, nextState;
  logic [INSTR_WIDTH-1:0] ir;
  logic [PC_WIDTH-1:0] nextPc;
  logic take, advance, unusedIr;
  always_comb begin
    take = state != READY && IMemAck;
    advance = state == READY && (PcSel == opcodes::PcInc || PcSel == opcodes::PcJmp);
    nextState = take ? READY : advance ? FETCH : state == FETCH ? WAIT : state;
    nextPc = !advance ? Pc : PcSel == opcodes::PcJmp ? JmpAddr : Pc + 1'b1;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= FETCH;
      Pc <= '0;
      ir <= '0;
    end else begin
      state <= nextState;
      Pc <= nextPc;
      if (take) ir <= IMemData;
    end
  // Reset is the only combinational input-to-output path: it kills a pending request at once
  assign IMemReq = !Reset && state != READY;
  assign IMemAddr = Pc;
  assign InstrValid = state == READY;
  assign OpCode = opcodes::opcodes_t'(ir[INSTR_WIDTH-1 -: 4]);
  assign Imm = ir[IMM_WIDTH-1:0];
  assign unusedIr = ^ir;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus checked against a transaction-level fetch model
module tb_fetch_unit;
  import opcodes::*;
  logic Clock = 0, Reset = 1;
  PcSel_t PcSel = PcWait;
  logic [7:0] JmpAddr = 0, IMemAddr, Imm, Pc;
  logic IMemReq, IMemAck = 0, InstrValid;
  logic [15:0] IMemData = 0;
  opcodes_t OpCode;
  int tests = 0, fails = 0;
  logic [15:0] mem [256];
  logic [7:0] mPc;
  logic [15:0] mIr;
  logic mValid;

  fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .PcSel(PcSel), .JmpAddr(JmpAddr),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
    .OpCode(OpCode), .Imm(Imm), .InstrValid(InstrValid), .Pc(Pc)
  );

  always #5 Clock = ~Clock;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task checkAll(input string tag);
    check({tag, ".pc"}, Pc, mPc);
    check({tag, ".addr"}, IMemAddr, mPc);
    check({tag, ".valid"}, InstrValid, mValid);
    check({tag, ".req"}, IMemReq, !mValid);
    check({tag, ".op"}, OpCode, mIr[15:12]);
    check({tag, ".imm"}, Imm, mIr[7:0]);
  endtask

  // Model view: a fetch is outstanding until acked, then the word is held until control moves the Pc.
  task cycle(input PcSel_t sel, input logic [7:0] jmp, input logic ack, input string tag);
    PcSel = sel;
    JmpAddr = jmp;
    IMemAck = ack;
    IMemData = ack ? mem[mPc] : 16'($urandom);
    @(posedge Clock);
    if (!mValid && ack) begin
      mIr = IMemData;
      mValid = 1;
    end else if (mValid && sel == PcInc) begin
      mPc = mPc + 8'd1;
      mValid = 0;
    end else if (mValid && sel == PcJmp) begin
      mPc = jmp;
      mValid = 0;
    end
    @(negedge Clock);
    checkAll(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h3A05;
    mPc = 0; mIr = 0; mValid = 0;
    #1;
    check("rst.req", IMemReq, 0);
    check("rst.valid", InstrValid, 0);
    check("rst.pc", Pc, 0);
    check("rst.op", OpCode, 0);
    @(negedge Clock);
    Reset = 0;
    #1 checkAll("post_rst");
    cycle(PcWait, 0, 1, "zero_wait");
    check("first.op", OpCode, 4'h3);
    check("first.imm", Imm, 8'h05);
    cycle(PcInc, 0, 0, "inc0");
    for (int i = 0; i < 3; i++) cycle(PcJmp, 8'h99, 0, "wait_hold");
    cycle(PcWait, 0, 1, "late_ack");
    for (int i = 0; i < 5; i++) cycle(PcWait, 0, 0, "hold");
    cycle(PcSel_t'(2'd3), 8'h11, 1, "undef_sel");
    cycle(PcWait, 0, 1, "ack_in_ready");
    cycle(PcInc, 0, 0, "inc1");
    check("inc1.pc", Pc, 8'h02);
    cycle(PcWait, 0, 1, "fetch2");
    cycle(PcJmp, 8'hFF, 0, "jmp_ff");
    cycle(PcWait, 0, 1, "fetch_ff");
    cycle(PcInc, 0, 0, "wrap");
    check("wrap.pc", Pc, 8'h00);
    cycle(PcWait, 0, 1, "fetch_wrap");
    cycle(PcJmp, 8'h40, 0, "jmp40");
    check("jmp40.addr", IMemAddr, 8'h40);
    cycle(PcJmp, 8'h77, 0, "jmp_in_wait");
    cycle(PcWait, 0, 1, "fetch40");
    cycle(PcJmp, 8'h40, 1, "jmp_self");
    cycle(PcWait, 0, 0, "self_wait");
    #2 Reset = 1;
    #1;
    check("midrst.req", IMemReq, 0);
    check("midrst.pc", Pc, 0);
    check("midrst.valid", InstrValid, 0);
    IMemAck = 1;
    IMemData = 16'hBEEF;
    @(posedge Clock);
    @(negedge Clock);
    check("rstack.op", OpCode, 0);
    check("rstack.imm", Imm, 0);
    mPc = 0; mIr = 0; mValid = 0;
    IMemAck = 0;
    Reset = 0;
    #1 checkAll("rst2");
    for (int i = 0; i < 3000; i++)
      cycle(PcSel_t'(2'($urandom)), 8'($urandom), 1'($urandom), "rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
